// File: rtl/fwd_pkg.sv
// fwd_pkg: shared types for the operand-forwarding / load-use hazard unit.
//
//   fwd_tag_t     destination tag carried down the EX..WB tag pipeline
//   FWD_SEL_RF    selector code meaning "operand comes from the register file"
//   stall_cnt_t   width of the saturating stall-cycle counter
//   tag_match()   true when a tag is a live, non-x0 writer of a given register
package fwd_pkg;

  // Tags hold rd at a fixed width so the struct can live in a package; narrower
  // register addresses are zero-extended on entry.
  localparam int unsigned FWD_RD_W = 8;

  typedef struct packed {
    logic                valid;
    logic [FWD_RD_W-1:0] rd;
    logic                we;
    logic                is_load;
  } fwd_tag_t;

  localparam fwd_tag_t FWD_TAG_BUBBLE = '0;

  localparam int unsigned FWD_SEL_RF = 0;

  typedef logic [31:0] stall_cnt_t;

  localparam stall_cnt_t STALL_CNT_MAX = '1;

  function automatic logic tag_match(input fwd_tag_t            tag,
                                     input logic [FWD_RD_W-1:0] rs);
    return tag.valid && tag.we && (tag.rd != '0) && (tag.rd == rs);
  endfunction

endpackage

// File: rtl/fwd_operand_sel.sv
// fwd_operand_sel: priority forwarding selector for a single EX source operand.
//
//   tag_i       tags of post-EX stages 1..DEPTH-1 (index = stage number)
//   rs_i        EX source register address (zero-extended)
//   rf_data_i   register-file value of this operand
//   fwd_data_i  stage k result at slice k-1
//   operand_o   selected operand value
//   sel_o       0 = register file, k = forwarded from stage k
module fwd_operand_sel
  import fwd_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned SEL_W    = $clog2(DEPTH)
) (
  input  fwd_tag_t [DEPTH-1:1]        tag_i,
  input  logic [FWD_RD_W-1:0]         rs_i,
  input  logic [XLEN-1:0]             rf_data_i,
  input  logic [(DEPTH-1)*XLEN-1:0]   fwd_data_i,
  output logic [XLEN-1:0]             operand_o,
  output logic [SEL_W-1:0]            sel_o
);

  logic hit;

  // Scan from the youngest stage outward; the first ready writer wins. A load
  // younger than LOAD_LAT has no data yet and is skipped (the stall logic keeps
  // a consumer from ever reaching EX while such a load is its only producer).
  always_comb begin
    hit       = 1'b0;
    sel_o     = SEL_W'(FWD_SEL_RF);
    operand_o = rf_data_i;
    for (int k = 1; k < DEPTH; k++) begin
      if (!hit && tag_match(tag_i[k], rs_i) && (!tag_i[k].is_load || k >= LOAD_LAT)) begin
        hit       = 1'b1;
        sel_o     = SEL_W'(k);
        operand_o = fwd_data_i[(k-1)*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding and load-use stall generation for the
// in-order RV32I pipeline. Tracks destination tags from EX (stage 0) to WB
// (stage DEPTH-1) and forwards the youngest ready result to each EX operand.
//
//   clk, rst_n     clock, asynchronous active-low reset
//   id_valid_i     valid instruction in ID
//   id_rs_i        ID source register addresses, NUM_SRC x REG_AW
//   id_rd_i        ID destination register
//   id_we_i        ID instruction writes rd
//   id_is_load_i   ID instruction is a load
//   flush_i        kill the ID instruction (it never enters EX), drop the stall
//   rf_data_i      EX register-file operands, NUM_SRC x XLEN
//   fwd_data_i     stage k result at slice k-1, (DEPTH-1) x XLEN
//   operand_o      forwarded EX operands, NUM_SRC x XLEN
//   fwd_sel_o      per operand: 0 = register file, k = stage k
//   stall_o        hold PC and IF/ID, insert EX bubble
//   stall_cnt_o    saturating count of stall cycles
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned NUM_SRC       = 2,
  parameter int unsigned REG_AW        = 5,
  parameter int unsigned DEPTH         = 3,
  parameter int unsigned LOAD_LAT      = 1,
  parameter int unsigned SEL_W         = $clog2(DEPTH),
  // Counter value after reset; nonzero only to exercise saturation quickly.
  parameter stall_cnt_t  STALL_CNT_RST = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        id_valid_i,
  input  logic [NUM_SRC*REG_AW-1:0]   id_rs_i,
  input  logic [REG_AW-1:0]           id_rd_i,
  input  logic                        id_we_i,
  input  logic                        id_is_load_i,
  input  logic                        flush_i,
  input  logic [NUM_SRC*XLEN-1:0]     rf_data_i,
  input  logic [(DEPTH-1)*XLEN-1:0]   fwd_data_i,
  output logic [NUM_SRC*XLEN-1:0]     operand_o,
  output logic [NUM_SRC*SEL_W-1:0]    fwd_sel_o,
  output logic                        stall_o,
  output logic [31:0]                 stall_cnt_o
);

  if (NUM_SRC < 1 || NUM_SRC > 3) begin : g_bad_num_src
    $error("fwd_hazard_unit: NUM_SRC must be 1..3");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("fwd_hazard_unit: DEPTH must be at least 2");
  end
  if (LOAD_LAT < 1 || LOAD_LAT > DEPTH - 1) begin : g_bad_load_lat
    $error("fwd_hazard_unit: LOAD_LAT must be 1..DEPTH-1");
  end
  if (REG_AW > FWD_RD_W) begin : g_bad_reg_aw
    $error("fwd_hazard_unit: REG_AW exceeds tag rd width");
  end

  fwd_tag_t [DEPTH-1:0]               tag_q, tag_d;
  fwd_tag_t                           id_tag;
  logic [NUM_SRC-1:0][FWD_RD_W-1:0]   ex_rs_q;
  stall_cnt_t                         stall_cnt_q;
  logic                               load_hit;
  logic                               stall;
  logic                               advance;

  assign id_tag = '{valid: 1'b1, rd: FWD_RD_W'(id_rd_i), we: id_we_i, is_load: id_is_load_i};

  // A load younger than LOAD_LAT stages past EX cannot supply data in time for
  // the instruction now in ID. Re-evaluated every cycle, so a load at j stalls
  // for LOAD_LAT - j cycles as it moves down the tag pipeline.
  always_comb begin
    load_hit = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int j = 0; j < LOAD_LAT; j++) begin
        if (tag_q[j].is_load &&
            tag_match(tag_q[j], FWD_RD_W'(id_rs_i[s*REG_AW +: REG_AW]))) begin
          load_hit = 1'b1;
        end
      end
    end
  end

  // Flush has priority: a killed ID instruction must not hold the front end.
  assign stall   = id_valid_i & ~flush_i & load_hit;
  assign advance = id_valid_i & ~stall & ~flush_i;

  always_comb begin
    tag_d    = tag_q;
    tag_d[0] = advance ? id_tag : FWD_TAG_BUBBLE;
    for (int k = 1; k < DEPTH; k++) begin
      tag_d[k] = tag_q[k-1];
    end
  end

  // Entry DEPTH-1 simply falls off: the register file writes before it reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q       <= '0;
      ex_rs_q     <= '0;
      stall_cnt_q <= STALL_CNT_RST;
    end else begin
      tag_q <= tag_d;
      if (advance) begin
        for (int s = 0; s < NUM_SRC; s++) begin
          ex_rs_q[s] <= FWD_RD_W'(id_rs_i[s*REG_AW +: REG_AW]);
        end
      end
      if (stall && (stall_cnt_q != STALL_CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_operand_sel #(
      .XLEN     (XLEN),
      .DEPTH    (DEPTH),
      .LOAD_LAT (LOAD_LAT),
      .SEL_W    (SEL_W)
    ) u_sel (
      .tag_i      (tag_q[DEPTH-1:1]),
      .rs_i       (ex_rs_q[s]),
      .rf_data_i  (rf_data_i[s*XLEN +: XLEN]),
      .fwd_data_i (fwd_data_i),
      .operand_o  (operand_o[s*XLEN +: XLEN]),
      .sel_o      (fwd_sel_o[s*SEL_W +: SEL_W])
    );
  end

  assign stall_o     = stall;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  localparam int DEPTH_A = 3;
  localparam int LAT_A   = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid, id_we, id_ld, flush;
  logic [9:0]  id_rs;
  logic [4:0]  id_rd;
  logic [63:0] rf_data, fwd_data;
  logic [95:0] fwd_data_b;

  logic [63:0] op_a, op_b, op_c;
  logic [3:0]  sel_a, sel_b, sel_c;
  logic        stall_a, stall_b, stall_c;
  logic [31:0] cnt_a, cnt_b, cnt_c;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the last DEPTH_A issued instructions (or bubbles), youngest first.
  typedef struct {bit v; int rd; bit we; bit ld;} ins_t;
  ins_t            hist[$];
  int              m_ex_rs[2];
  longint unsigned m_cnt;
  bit              exp_stall;
  int              exp_sel[2];
  logic [31:0]     exp_op[2];

  always #5 clk = ~clk;

  fwd_hazard_unit dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rd_i(id_rd),
    .id_we_i(id_we), .id_is_load_i(id_ld), .flush_i(flush), .rf_data_i(rf_data),
    .fwd_data_i(fwd_data), .operand_o(op_a), .fwd_sel_o(sel_a), .stall_o(stall_a),
    .stall_cnt_o(cnt_a)
  );

  fwd_hazard_unit #(.DEPTH(4), .LOAD_LAT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rd_i(id_rd),
    .id_we_i(id_we), .id_is_load_i(id_ld), .flush_i(flush), .rf_data_i(rf_data),
    .fwd_data_i(fwd_data_b), .operand_o(op_b), .fwd_sel_o(sel_b), .stall_o(stall_b),
    .stall_cnt_o(cnt_b)
  );

  fwd_hazard_unit #(.STALL_CNT_RST(32'hFFFF_FFFE)) dut_c (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rd_i(id_rd),
    .id_we_i(id_we), .id_is_load_i(id_ld), .flush_i(flush), .rf_data_i(rf_data),
    .fwd_data_i(fwd_data), .operand_o(op_c), .fwd_sel_o(sel_c), .stall_o(stall_c),
    .stall_cnt_o(cnt_c)
  );

  function automatic void model_reset();
    ins_t b = '{v: 1'b0, rd: 0, we: 1'b0, ld: 1'b0};
    hist.delete();
    for (int i = 0; i < DEPTH_A; i++) hist.push_back(b);
    m_ex_rs = '{0, 0};
    m_cnt   = 0;
  endfunction

  function automatic bit writes(ins_t t, int r);
    return t.v && t.we && t.rd != 0 && t.rd == r;
  endfunction

  function automatic void model_eval();
    exp_stall = 1'b0;
    if (id_valid && !flush)
      for (int s = 0; s < 2; s++)
        for (int j = 0; j < LAT_A; j++)
          if (hist[j].ld && writes(hist[j], int'(id_rs[s*5 +: 5]))) exp_stall = 1'b1;
    for (int s = 0; s < 2; s++) begin
      exp_sel[s] = 0;
      exp_op[s]  = rf_data[s*32 +: 32];
      for (int k = 1; k < DEPTH_A; k++)
        if (exp_sel[s] == 0 && writes(hist[k], m_ex_rs[s]) && (!hist[k].ld || k >= LAT_A)) begin
          exp_sel[s] = k;
          exp_op[s]  = fwd_data[(k-1)*32 +: 32];
        end
    end
  endfunction

  // Advance one clock; the model follows the same edge.
  task automatic step();
    bit   adv;
    ins_t ni;
    model_eval();
    @(posedge clk);
    adv = id_valid && !exp_stall && !flush;
    ni  = adv ? '{v: 1'b1, rd: int'(id_rd), we: id_we, ld: id_ld}
              : '{v: 1'b0, rd: 0, we: 1'b0, ld: 1'b0};
    hist.push_front(ni);
    void'(hist.pop_back());
    if (adv) begin
      m_ex_rs[0] = int'(id_rs[4:0]);
      m_ex_rs[1] = int'(id_rs[9:5]);
    end
    if (exp_stall && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs = '0; id_rd = '0; id_we = 1'b0; id_ld = 1'b0; flush = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rs0, input logic [4:0] rs1, input logic [4:0] rd,
                       input logic we, input logic ld);
    id_valid = 1'b1; id_rs = {rs1, rs0}; id_rd = rd; id_we = we; id_ld = ld; flush = 1'b0;
  endtask

  task automatic randomize_inputs();
    id_valid = ($urandom_range(3) != 0);
    id_rs    = {5'($urandom_range(3)), 5'($urandom_range(3))};
    id_rd    = 5'($urandom_range(3));
    id_we    = ($urandom_range(3) != 0);
    id_ld    = ($urandom_range(9) < 3);
    flush    = ($urandom_range(9) == 0);
    rf_data  = {$urandom, $urandom};
    fwd_data = {$urandom, $urandom};
    fwd_data_b = {$urandom, $urandom, $urandom};
  endtask

  task automatic do_reset();
    idle();
    rf_data = {$urandom, $urandom};
    rst_n = 1'b0;
    model_reset();
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    randomize_inputs();
    #2;
    n_checks++;
    if (op_a !== rf_data) begin
      n_errors++; $display("FAIL reset_operand: got %h expected %h", op_a, rf_data);
    end
    n_checks++;
    if (sel_a !== 4'b0000) begin
      n_errors++; $display("FAIL reset_sel: got %b expected 0000", sel_a);
    end
    n_checks++;
    if (stall_a !== 1'b0) begin
      n_errors++; $display("FAIL reset_stall: got %b expected 0", stall_a);
    end
    n_checks++;
    if (cnt_a !== 32'd0) begin
      n_errors++; $display("FAIL reset_cnt: got %h expected 0", cnt_a);
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(5'd1, 5'd0, 5'd5, 1'b1, 1'b0);   // addi x5
    step();
    issue(5'd5, 5'd5, 5'd6, 1'b1, 1'b0);   // add x6,x5,x5
    @(negedge clk);
    n_checks++;
    if (stall_a !== 1'b0) begin
      n_errors++; $display("FAIL b2b_no_stall: got %b expected 0", stall_a);
    end
    step();
    idle();
    fwd_data = {32'h0000_DEAD, 32'h0000_1234};
    @(negedge clk);
    n_checks++;
    if (op_a !== {2{32'h0000_1234}} || sel_a !== 4'b0101) begin
      n_errors++;
      $display("FAIL b2b_mem: got op %h sel %b expected op %h sel 0101", op_a, sel_a,
               {2{32'h0000_1234}});
    end
    step();
    fwd_data = {32'h0000_1234, 32'h0000_9999};
    @(negedge clk);
    n_checks++;
    if (op_a !== {2{32'h0000_1234}} || sel_a !== 4'b1010) begin
      n_errors++;
      $display("FAIL b2b_wb: got op %h sel %b expected op %h sel 1010", op_a, sel_a,
               {2{32'h0000_1234}});
    end
    step();
  endtask

  task automatic test_youngest();
    do_reset();
    issue(5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
    step();
    issue(5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
    step();
    issue(5'd7, 5'd3, 5'd10, 1'b1, 1'b0);
    step();
    idle();
    fwd_data = {32'h0000_5555, 32'h0000_AAAA};
    @(negedge clk);
    n_checks++;
    if (op_a !== {rf_data[63:32], 32'h0000_AAAA} || sel_a !== 4'b0001) begin
      n_errors++;
      $display("FAIL youngest: got op %h sel %b expected op %h sel 0001", op_a, sel_a,
               {rf_data[63:32], 32'h0000_AAAA});
    end
    step();
  endtask

  task automatic test_load_use();
    do_reset();
    issue(5'd1, 5'd0, 5'd8, 1'b1, 1'b1);   // lw x8
    step();
    issue(5'd8, 5'd0, 5'd9, 1'b1, 1'b0);   // add x9,x8,x0
    @(negedge clk);
    n_checks++;
    if (stall_a !== 1'b1) begin
      n_errors++; $display("FAIL lu_stall: got %b expected 1", stall_a);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (stall_a !== 1'b0 || cnt_a !== 32'd1) begin
      n_errors++; $display("FAIL lu_release: got stall %b cnt %0d expected 0 / 1", stall_a, cnt_a);
    end
    step();
    idle();
    fwd_data = {32'hCAFE_F00D, 32'h0BAD_0BAD};
    @(negedge clk);
    n_checks++;
    if (op_a !== {rf_data[63:32], 32'hCAFE_F00D} || sel_a !== 4'b0010) begin
      n_errors++;
      $display("FAIL lu_forward: got op %h sel %b expected op %h sel 0010", op_a, sel_a,
               {rf_data[63:32], 32'hCAFE_F00D});
    end
    step();
    // Reset in the middle of a stall clears it without waiting for a clock.
    issue(5'd1, 5'd0, 5'd8, 1'b1, 1'b1);
    step();
    issue(5'd8, 5'd8, 5'd9, 1'b1, 1'b0);
    @(negedge clk);
    n_checks++;
    if (stall_a !== 1'b1) begin
      n_errors++; $display("FAIL lu_stall2: got %b expected 1", stall_a);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (stall_a !== 1'b0 || cnt_a !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_mid_stall: got stall %b cnt %0d expected 0 / 0", stall_a, cnt_a);
    end
    do_reset();
  endtask

  task automatic test_load_lat2();
    do_reset();
    issue(5'd1, 5'd0, 5'd8, 1'b1, 1'b1);
    step();
    issue(5'd8, 5'd0, 5'd9, 1'b1, 1'b0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (stall_b !== 1'b1) begin
        n_errors++; $display("FAIL lat2_stall cycle %0d: got %b expected 1", c, stall_b);
      end
      step();
    end
    @(negedge clk);
    n_checks++;
    if (stall_b !== 1'b0 || cnt_b !== 32'd2) begin
      n_errors++;
      $display("FAIL lat2_release: got stall %b cnt %0d expected 0 / 2", stall_b, cnt_b);
    end
    step();
    idle();
    fwd_data_b = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    @(negedge clk);
    n_checks++;
    if (op_b !== {rf_data[63:32], 32'h3333_3333} || sel_b !== 4'b0011) begin
      n_errors++;
      $display("FAIL lat2_forward: got op %h sel %b expected op %h sel 0011", op_b, sel_b,
               {rf_data[63:32], 32'h3333_3333});
    end
    step();
  endtask

  task automatic test_x0_flush();
    do_reset();
    issue(5'd1, 5'd2, 5'd0, 1'b1, 1'b0);   // addi x0
    step();
    issue(5'd0, 5'd0, 5'd11, 1'b1, 1'b0);  // reads x0
    step();
    idle();
    @(negedge clk);
    n_checks++;
    if (op_a !== rf_data || sel_a !== 4'b0000) begin
      n_errors++;
      $display("FAIL x0_no_fwd: got op %h sel %b expected op %h sel 0000", op_a, sel_a, rf_data);
    end
    step();
    issue(5'd1, 5'd0, 5'd8, 1'b1, 1'b1);   // lw x8
    step();
    issue(5'd8, 5'd0, 5'd9, 1'b1, 1'b0);   // add x9,x8 killed by flush
    flush = 1'b1;
    @(negedge clk);
    n_checks++;
    if (stall_a !== 1'b0) begin
      n_errors++; $display("FAIL flush_stall: got %b expected 0", stall_a);
    end
    step();
    issue(5'd9, 5'd0, 5'd10, 1'b1, 1'b0);  // would forward x9 if the flushed op had entered EX
    step();
    idle();
    @(negedge clk);
    n_checks++;
    if (sel_a !== 4'b0000 || op_a !== rf_data) begin
      n_errors++;
      $display("FAIL flush_bubble: got op %h sel %b expected op %h sel 0000", op_a, sel_a,
               rf_data);
    end
    step();
  endtask

  task automatic test_saturation();
    do_reset();
    n_checks++;
    if (cnt_c !== 32'hFFFF_FFFE) begin
      n_errors++; $display("FAIL sat_preload: got %h expected fffffffe", cnt_c);
    end
    for (int i = 0; i < 3; i++) begin
      issue(5'd1, 5'd0, 5'd8, 1'b1, 1'b1);
      step();
      issue(5'd8, 5'd0, 5'd9, 1'b1, 1'b0);
      @(negedge clk);
      n_checks++;
      if (stall_c !== 1'b1) begin
        n_errors++; $display("FAIL sat_stall %0d: got %b expected 1", i, stall_c);
      end
      step();
      @(negedge clk);
      n_checks++;
      if (cnt_c !== 32'hFFFF_FFFF || cnt_a !== 32'(i + 1)) begin
        n_errors++;
        $display("FAIL sat_count %0d: got sat %h plain %0d expected ffffffff / %0d", i, cnt_c,
                 cnt_a, i + 1);
      end
      step();
    end
    idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      randomize_inputs();
      @(negedge clk);
      model_eval();
      n_checks++;
      if (stall_a !== exp_stall || stall_c !== exp_stall) begin
        n_errors++;
        $display("FAIL rand_stall %0d: got %b/%b expected %b", c, stall_a, stall_c, exp_stall);
      end
      n_checks++;
      if (sel_a !== {exp_sel[1][1:0], exp_sel[0][1:0]} || sel_c !== sel_a) begin
        n_errors++;
        $display("FAIL rand_sel %0d: got %b/%b expected %0d,%0d", c, sel_a, sel_c,
                 exp_sel[1], exp_sel[0]);
      end
      n_checks++;
      if (op_a !== {exp_op[1], exp_op[0]} || op_c !== {exp_op[1], exp_op[0]}) begin
        n_errors++;
        $display("FAIL rand_op %0d: got %h/%h expected %h", c, op_a, op_c,
                 {exp_op[1], exp_op[0]});
      end
      n_checks++;
      if (cnt_a !== m_cnt[31:0]) begin
        n_errors++; $display("FAIL rand_cnt %0d: got %0d expected %0d", c, cnt_a, m_cnt);
      end
      step();
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rf_data = '0; fwd_data = '0; fwd_data_b = '0;
    model_reset();
    test_reset();
    test_back_to_back();
    test_youngest();
    test_load_use();
    test_load_lat2();
    test_x0_flush();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
